aes128_enc_iter: RTL and testbench

Iterative AES-128 encryption core, the forward counterpart of the existing decryption top. Computes one round per clock with on-the-fly key expansion. Latches a 128-bit plaintext and key via a valid/ready handshake and presents the ciphertext with a valid/ready output handshake. Intended to sit beside the decryptor so encrypt/decrypt round-trips can be run in one bench.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes128_enc_iter.sv | 98 +++++++++
 tb/tb_aes128_enc_iter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and linear round helpers.
// Byte 0 of a block lives in element 15 (bits 127:120).
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [31:0] word_t;
  typedef logic [15:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam byte_t RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t rcon_of(logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10)
      return RCON[r - 4'd1];
    return 8'h00;
  endfunction

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t shift_rows(state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(15 - (4*c + r))] = s[4'(15 - (4*((c + r) % 4) + r))];
    return o;
  endfunction

  function automatic state_t mix_columns(state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4'(15 - 4*c)];
      a1 = s[4'(14 - 4*c)];
      a2 = s[4'(13 - 4*c)];
      a3 = s[4'(12 - 4*c)];
      o[4'(15 - 4*c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[4'(14 - 4*c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[4'(13 - 4*c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[4'(12 - 4*c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box.
// Entry 0 sits in the top byte of the table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = {a, 3'b000};
  assign y   = TBL[11'd2047 - idx -: 8];

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock,
// key schedule expanded on the fly alongside the data.
module aes128_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] aes_input,
  input  logic [127:0] aes_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] aes_output
);

  fsm_e   state_q, state_d;
  logic   [3:0] round_ctr;
  state_t state_reg, rk_reg;
  state_t sb, sr, mc, round_out;
  state_t rk_next;
  word_t  rot, sub, temp;
  word_t  w0, w1, w2, w3;
  logic   last;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sb (.a(state_reg[i]), .y(sb[i]));
  end

  assign rot = {rk_reg[2], rk_reg[1], rk_reg[0], rk_reg[3]};

  for (genvar j = 0; j < 4; j++) begin : g_key
    aes_sbox u_ks (.a(rot[8*j +: 8]), .y(sub[8*j +: 8]));
  end

  assign temp    = sub ^ {rcon_of(round_ctr), 24'h0};
  assign w0      = rk_reg[15:12] ^ temp;
  assign w1      = rk_reg[11:8] ^ w0;
  assign w2      = rk_reg[7:4] ^ w1;
  assign w3      = rk_reg[3:0] ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  // Final round skips MixColumns.
  assign last      = (round_ctr == 4'd10);
  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign round_out = (last ? sr : mc) ^ rk_next;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (in_valid) state_d = BUSY;
      BUSY:
        if (round_ctr == 4'd0 || round_ctr > 4'd10)
          state_d = IDLE;
        else if (last)
          state_d = DONE;
      DONE:
        if (out_ready) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      round_ctr  <= 4'd0;
      state_reg  <= '0;
      rk_reg     <= '0;
      aes_output <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (in_valid) begin
          state_reg <= aes_input ^ aes_key;
          rk_reg    <= aes_key;
          round_ctr <= 4'd1;
        end
      end else if (state_q == BUSY) begin
        state_reg <= round_out;
        rk_reg    <= rk_next;
        round_ctr <= round_ctr + 4'd1;
        if (last) begin
          aes_output <= round_out;
          out_valid  <= 1'b1;
        end
      end else if (state_q == DONE) begin
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Scoreboard bench for the iterative AES-128 encryptor
// using FIPS-197 known-answer vectors.
module tb_aes128_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] aes_input = '0;
  logic [127:0] aes_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] aes_output;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_enc_iter dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .aes_input(aes_input),
    .aes_key(aes_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aes_output(aes_output)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act,
                                logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted ciphertext must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got %h want none", aes_output);
      end else begin
        check("ciphertext", aes_output, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp, output int acc);
    int n = 0;
    aes_input = pt;
    aes_key   = key;
    in_valid  = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("accept_timeout", 128'(n), 128'(0));
    exp_q.push_back(exp);
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int acc, acc2, n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_output", aes_output, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // App. B with a consumer that is always ready
    out_ready = 1'b1;
    send(PT1, K1, CT1, acc);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency_v1", 128'(n), 128'(10));
    @(posedge clk); #1;
    check("valid_one_cycle", 128'(out_valid), 128'(0));
    check("in_ready_after", 128'(in_ready), 128'(1));
    check("output_kept", aes_output, CT1);
    drain();

    // App. C.1
    send(PT2, K2, CT2, acc);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency_v2", 128'(n), 128'(10));
    drain();

    // All-zero block with back-pressure
    out_ready = 1'b0;
    send('0, '0, CT0, acc);
    in_valid = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_output", aes_output, CT0);
      check("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    drain();

    // Input changes and in_valid pulse while busy are ignored
    send(PT1, K1, CT1, acc);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    aes_input = PT2;
    aes_key   = K2;
    in_valid  = 1'b1;
    check("busy_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    repeat (15) @(posedge clk);
    #1;
    check("no_extra_valid", 128'(out_valid), 128'(0));

    // Reset in the middle of vector 1, then vector 2
    send(PT1, K1, CT1, acc);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_output", aes_output, '0);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(PT2, K2, CT2, acc);
    in_valid = 1'b0;
    wait_valid(n);
    check("latency_after_rst", 128'(n), 128'(10));
    drain();

    // Back-to-back with in_valid and out_ready held high
    send(PT1, K1, CT1, acc);
    send(PT2, K2, CT2, acc2);
    in_valid = 1'b0;
    check("issue_interval", 128'(acc2 - acc), 128'(12));
    drain();

    repeat (5) @(posedge clk);
    #1;
    check("final_queue", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
